// File: rtl/counter_cmd_arbiter_if.sv
// Command bus between two requesters, the counter datapath and counter_cmd_arbiter.
// The master side drives requests and datapath status; the slave (arbiter) drives grants and strobes.
interface counter_cmd_arbiter_if #(
  parameter int NW = 4
);
  logic          req0;
  logic          req1;
  logic [1:0]    cmd0;
  logic [1:0]    cmd1;
  logic [NW-1:0] n0;
  logic [NW-1:0] n1;
  logic          z;
  logic          m;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic          sat;
  logic          busy;
  logic          op;
  logic          c_clr;
  logic          c_ld;

  modport master (
    output req0, req1, cmd0, cmd1, n0, n1, z, m,
    input  gnt0, gnt1, done0, done1, sat, busy, op, c_clr, c_ld
  );

  modport slave (
    input  req0, req1, cmd0, cmd1, n0, n1, z, m,
    output gnt0, gnt1, done0, done1, sat, busy, op, c_clr, c_ld
  );
endinterface

// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter that sequences INC/DEC/CLR commands from two requesters onto the counter datapath.
// Define ARB_FIXED_PRIO_EN to make requester 0 always win simultaneous requests.
module counter_cmd_arbiter #(
  parameter int NW  = 4,
  parameter int GAP = 2
) (
  input logic                   clk,
  input logic                   reset,
  counter_cmd_arbiter_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_INC = 2'b01;
  localparam logic [1:0] CMD_DEC = 2'b10;
  localparam logic [1:0] CMD_CLR = 2'b11;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [2:0]    state_q, state_d;
  logic [1:0]    cmd_q,   cmd_d;
  logic [NW-1:0] rem_q,   rem_d;
  logic          id_q,    id_d;
  logic          sat_q,   sat_d;
  logic [3:0]    gap_q,   gap_d;
`ifndef ARB_FIXED_PRIO_EN
  logic          ptr_q,   ptr_d;
`endif

  logic win_id;
  logic hit_limit;
  logic is_step;
  logic is_count_cmd;

`ifdef ARB_FIXED_PRIO_EN
  assign win_id = ~bus.req0;
`else
  assign win_id = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
`endif

  assign is_count_cmd = (cmd_q == CMD_INC) || (cmd_q == CMD_DEC);
  assign hit_limit    = ((cmd_q == CMD_INC) && bus.m) || ((cmd_q == CMD_DEC) && bus.z);
  assign is_step      = (state_q == ST_STEP);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d = state_q;
    cmd_d   = cmd_q;
    rem_d   = rem_q;
    id_d    = id_q;
    sat_d   = sat_q;
    gap_d   = gap_q;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          cmd_d   = win_id ? bus.cmd1 : bus.cmd0;
          rem_d   = win_id ? bus.n1   : bus.n0;
          id_d    = win_id;
          sat_d   = 1'b0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
`ifndef ARB_FIXED_PRIO_EN
        ptr_d = ~id_q;
`endif
        if ((cmd_q == CMD_NOP) || (is_count_cmd && (rem_q == '0))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_STEP;
        end
      end

      ST_STEP: begin
        if (cmd_q == CMD_CLR) begin
          state_d = ST_DONE;
        end else if (hit_limit) begin
          sat_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - NW'(1);
          if (rem_q == NW'(1)) begin
            state_d = ST_DONE;
          end else if (GAP > 0) begin
            gap_d   = GAP_LAST;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_STEP;
          end
        end
      end

      ST_WAIT: begin
        if (gap_q == 4'd0) begin
          state_d = ST_STEP;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      rem_q   <= '0;
      id_q    <= 1'b0;
      sat_q   <= 1'b0;
      gap_q   <= 4'd0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      // NOTE: state flops use <= so every register updates together at the edge.
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
      gap_q   <= gap_d;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.gnt0  = (state_q == ST_GRANT) && !id_q;
  assign bus.gnt1  = (state_q == ST_GRANT) &&  id_q;
  assign bus.done0 = (state_q == ST_DONE)  && !id_q;
  assign bus.done1 = (state_q == ST_DONE)  &&  id_q;
  assign bus.sat   = (state_q == ST_DONE)  &&  sat_q;
  assign bus.busy  = (state_q != ST_IDLE);

  // z/m qualify the load inside the STEP cycle itself so that GAP=0 still acts on fresh status.
  assign bus.c_ld  = is_step && is_count_cmd && !hit_limit;
  assign bus.c_clr = is_step && (cmd_q == CMD_CLR);
  assign bus.op    = bus.c_ld && (cmd_q == CMD_DEC);

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Self-checking bench for counter_cmd_arbiter: directed scenarios plus random traffic against a
// transaction-level model (winner, strobe count/timing, completion cycle, sat) and a 4-bit counter.
module tb_counter_cmd_arbiter;

  localparam int NW   = 4;
  localparam int GAP  = 2;
  localparam int CMAX = 15;

  localparam logic [1:0] C_NOP = 2'b00;
  localparam logic [1:0] C_INC = 2'b01;
  localparam logic [1:0] C_DEC = 2'b10;
  localparam logic [1:0] C_CLR = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  counter_cmd_arbiter_if #(.NW(NW)) bus ();

  counter_cmd_arbiter #(.NW(NW), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // datapath model
  int cnt = 0;

  // transaction-level reference
  logic [1:0] req_prev  = 2'b00;
  bit         sticky    = 1'b0;
  bit         ptr       = 1'b0;
  bit         act       = 1'b0;
  int         act_id    = 0;
  logic [1:0] act_cmd   = C_NOP;
  int         g_cyc     = 0;
  int         d_cyc     = 0;
  int         idle_from = 0;
  int         exp_k     = 0;
  bit         exp_sat   = 1'b0;
  int         start_cnt = 0;
  int         ld_seen   = 0;
  int         clr_seen  = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, actual, expected);
  endtask

  task automatic drive_req(input int id, input logic r, input logic [1:0] c, input int n);
    if (id == 0) begin
      bus.req0 = r; bus.cmd0 = c; bus.n0 = NW'(n);
    end else begin
      bus.req1 = r; bus.cmd1 = c; bus.n1 = NW'(n);
    end
  endtask

  task automatic set_cnt(input int v);
    cnt   = v;
    bus.z = (cnt == 0);
    bus.m = (cnt == CMAX);
  endtask

  // One clock cycle: check outputs at the falling edge, then update datapath status and requesters.
  task automatic tick(input bit rnd);
    logic [1:0] exp_gnt, exp_done, gv, dv;
    bit         live;
    int         w, n, head, cnt_nxt, exp_cnt;
    @(negedge clk);
    cyc++;
    exp_gnt  = 2'b00;
    exp_done = 2'b00;
    if (act && cyc == d_cyc) exp_done[act_id] = 1'b1;
    live = act;

    if (!act && (cyc - 1) >= idle_from && req_prev != 2'b00) begin
`ifdef ARB_FIXED_PRIO_EN
      w = req_prev[0] ? 0 : 1;
`else
      w = (req_prev == 2'b11) ? int'(ptr) : (req_prev[1] ? 1 : 0);
      ptr = (w == 0);
`endif
      exp_gnt[w] = 1'b1;
      act     = 1'b1;
      live    = 1'b1;
      act_id  = w;
      g_cyc   = cyc;
      act_cmd = (w == 1) ? bus.cmd1 : bus.cmd0;
      n       = (w == 1) ? int'(bus.n1) : int'(bus.n0);
      start_cnt = cnt;
      head    = (act_cmd == C_INC) ? (CMAX - cnt) : cnt;
      ld_seen  = 0;
      clr_seen = 0;
      exp_k    = 0;
      exp_sat  = 1'b0;
      if (act_cmd == C_NOP || (act_cmd != C_CLR && n == 0)) begin
        d_cyc = cyc + 1;
      end else if (act_cmd == C_CLR) begin
        d_cyc = cyc + 2;
      end else begin
        exp_sat = (n > head);
        exp_k   = exp_sat ? head : n;
        d_cyc   = exp_sat ? cyc + 2 + exp_k * (1 + GAP) : cyc + 1 + n + (n - 1) * GAP;
      end
    end

    gv = {bus.gnt1, bus.gnt0};
    dv = {bus.done1, bus.done0};
    check("gnt",  gv, exp_gnt);
    check("done", dv, exp_done);
    check("sat",  bus.sat, (exp_done != 2'b00) ? int'(exp_sat) : 0);
    check("busy", bus.busy, live);
    check("ld_clr_excl", bus.c_ld & bus.c_clr, 0);
    if (!live) check("idle_strobes", {bus.op, bus.c_clr, bus.c_ld}, 0);
    if (bus.c_ld) begin
      check("ld_cycle", cyc, g_cyc + 1 + ld_seen * (GAP + 1));
      check("op", bus.op, int'(act_cmd == C_DEC));
      ld_seen++;
    end
    if (bus.c_clr) begin
      check("clr_cycle", cyc, g_cyc + 1);
      clr_seen++;
    end

    cnt_nxt = bus.c_clr ? 0 : (bus.c_ld ? (bus.op ? (cnt + CMAX) % (CMAX + 1) : (cnt + 1) % (CMAX + 1)) : cnt);

    if (exp_done != 2'b00) begin
      exp_cnt = (act_cmd == C_CLR) ? 0 :
                (act_cmd == C_INC) ? start_cnt + exp_k :
                (act_cmd == C_DEC) ? start_cnt - exp_k : start_cnt;
      check("n_loads",  ld_seen, exp_k);
      check("n_clears", clr_seen, int'(act_cmd == C_CLR));
      check("count",    cnt_nxt, exp_cnt);
      act       = 1'b0;
      idle_from = cyc + 1;
    end
    req_prev = {bus.req1, bus.req0};

    @(posedge clk);
    #1;
    set_cnt(cnt_nxt);
    for (int i = 0; i < 2; i++) begin
      if (gv[i] && !sticky)
        drive_req(i, 1'b0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end
    if (rnd) begin
      if (!bus.req0 && $urandom_range(0, 3) == 0)
        drive_req(0, 1'b1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      if (!bus.req1 && $urandom_range(0, 3) == 0)
        drive_req(1, 1'b1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end
  endtask

  task automatic run_idle(input int budget);
    int k;
    k = 0;
    while ((act || bus.req0 || bus.req1) && k < budget) begin
      tick(1'b0);
      k++;
    end
    check("drain", int'(act || bus.req0 || bus.req1), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_req(0, 1'b0, C_NOP, 0);
    drive_req(1, 1'b0, C_NOP, 0);
    sticky = 1'b0;
    @(negedge clk);
    cyc++;
    check("reset_outputs", {bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.sat,
                            bus.busy, bus.op, bus.c_clr, bus.c_ld}, 0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    act       = 1'b0;
    ptr       = 1'b0;
    idle_from = cyc + 1;
    req_prev  = 2'b00;
  endtask

  initial begin
    drive_req(0, 1'b0, C_NOP, 0);
    drive_req(1, 1'b0, C_NOP, 0);
    set_cnt(0);
    do_reset();

    // single INC from zero, then saturation on m after two loads
    set_cnt(0);  drive_req(0, 1'b1, C_INC, 3); run_idle(40);
    set_cnt(13); drive_req(1, 1'b1, C_INC, 5); run_idle(40);

    // CLR, DEC n=0, DEC at zero
    set_cnt(7);  drive_req(0, 1'b1, C_CLR, 9); run_idle(20);
    drive_req(1, 1'b1, C_DEC, 0);              run_idle(20);
    set_cnt(0);  drive_req(0, 1'b1, C_DEC, 3); run_idle(20);

    // contention from reset with both requests held
    do_reset();
    set_cnt(5);
    sticky = 1'b1;
    drive_req(0, 1'b1, C_DEC, 1);
    drive_req(1, 1'b1, C_INC, 1);
    repeat (40) tick(1'b0);
    sticky = 1'b0;
    run_idle(60);

    // reset during WAIT of INC n=4 while the pointer sits at 1
    do_reset();
    set_cnt(2);
    drive_req(0, 1'b1, C_INC, 4);
    repeat (4) tick(1'b0);
    do_reset();
    repeat (3) tick(1'b0);
    drive_req(0, 1'b1, C_INC, 1);
    drive_req(1, 1'b1, C_DEC, 1);
    run_idle(60);

    // random traffic
    repeat (3000) tick(1'b1);
    run_idle(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
